split_data: RTL
===============

Name: split_data

Overview:
- Read-path counterpart of the VDMA write-side packer.
- Takes wide AXI read-data words (ISIZE bits) and unpacks them into a narrow pixel stream (OSIZE bits), MSB-first.
- Pixels may straddle word boundaries when ISIZE%OSIZE != 0.
- In LINE mode each video line starts on a fresh word, and the padding bits at the end of the line's last word are discarded.

Parameters:
- ISIZE, 256, input word width in bits; must satisfy ISIZE >= OSIZE and ISIZE+2*OSIZE <= 2047.
- OSIZE, 24, output pixel width in bits.
- MODE, "ONCE", "ONCE" = continuous unpack with no line handling; "LINE" = per-line alignment using line_pixels.

Ports:
- clock  input  1  single clock.
- rst_n  input  1  reset, asynchronous, active-low.
- ialign  input  1  frame/resync strobe; synchronous clear.
- ivalid  input  1  input word valid.
- iready  output  1  block accepts a word this cycle.
- idata  input  ISIZE  input word; first pixel is at idata[ISIZE-1 -: OSIZE].
- line_pixels  input  16  pixels per line (LINE mode only); sampled on ialign and on each olast pop.
- ovalid  output  1  pixel valid.
- oready  input  1  downstream accepts pixel.
- odata  output  OSIZE  pixel.
- olast  output  1  qualifies the last pixel of a line (LINE mode only); 0 in ONCE mode.

Behaviour:
- State:
  - bit buffer buf of width ISIZE+2*OSIZE, MSB-aligned;
  - bit count cnt (11 bits);
  - LINE mode adds pixel counter pcnt (16 bits), remaining-fetch counter rbits (signed 32 bits), and latched line length lpix.
- Reset:
  - rst_n low asynchronously clears buf, cnt, pcnt, rbits and lpix.
  - ovalid=0, olast=0, odata=0, and iready is forced 0 while rst_n is low.
- iready:
  - ONCE mode: iready = (cnt < 2*OSIZE) & ~ialign.
  - LINE mode: iready additionally requires rbits > 0.
  - iready depends only on registered state and ialign, never on oready.
- Load (ivalid & iready):
  - idata is appended directly below the existing cnt bits of buf.
  - cnt += ISIZE.
  - LINE mode: rbits -= ISIZE.
- Output:
  - ovalid = cnt >= OSIZE.
  - odata = buf[top -: OSIZE].
  - Latency: a word accepted into an empty buffer in cycle N gives ovalid in cycle N+1.
- Pop (ovalid & oready): buf shifts left by OSIZE and cnt -= OSIZE.
- Simultaneous load and pop:
  - Both take effect in the same cycle.
  - The new word lands below the post-shift bits; cnt += ISIZE-OSIZE.
- Hold: while ovalid & ~oready, odata and ovalid remain stable.
- LINE mode, line setup:
  - On ialign, lpix <= line_pixels and rbits <= line_pixels*OSIZE.
  - After reset, rbits=0, so iready stays 0 until the first ialign.
- LINE mode, olast:
  - olast = ovalid & (pcnt == lpix-1).
  - pcnt increments on each pop.
- LINE mode, line end (pop with olast=1):
  - pcnt <= 0 and cnt <= 0; the remaining padding bits are dropped.
  - lpix <= line_pixels and rbits <= line_pixels*OSIZE.
  - No load can coincide with this pop, because rbits <= 0 has already held iready low.
- line_pixels = 0: rbits stays 0, iready stays 0, and no output is produced until an ialign with a nonzero value.
- ialign:
  - Has priority over load and pop.
  - Next cycle: cnt=0, pcnt=0, ovalid=0, and any word presented in the ialign cycle is not accepted.
  - Any pixel not yet popped is dropped.
- Throughput:
  - ONCE mode sustains one pixel per cycle.
  - LINE mode adds at most one bubble cycle per line, at the line boundary.

Optional Feature:
- Macro: SPLIT_DATA_UNDERRUN_CNT_EN.
- Defined:
  - Adds output ounderrun_cnt (16 bits). It increments, saturating at 16'hFFFF, in every cycle with oready=1, ovalid=0 and (LINE mode) pcnt != 0, or (ONCE mode) at least one pixel popped since the last ialign.
  - Cleared by reset and by ialign.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. ONCE mode, 3 words of counting bytes, oready=1: exactly 32 pixels (768/24), pixel k = concat[767-24k -: 24]; ovalid=0 afterwards; one pixel per cycle with no bubbles.
2. ONCE mode, straddle: word0 = all A5, word1 = all 3C: pixel 10 = {word0[15:0], word1[255:248]} = 24'hA5A53C; pixel 11 = word1[247:224].
3. LINE mode, line_pixels=12, ialign, then 4 words: 2 words per line; olast on pixels 11 and 23; the line-1 first pixel = word2[255:232]; 224 padding bits discarded per line; iready low between the second word and the olast pop.
4. Backpressure: oready toggles 1,0,0,1 randomly over 10 words: no pixel lost or duplicated; odata is stable in every ovalid&~oready cycle; iready never asserts with cnt >= 48.
5. ialign after 5 pixels of a line: next cycle ovalid=0, cnt=0, pcnt=0; the first pixel of the following word = its [255:232]; with the macro defined, ounderrun_cnt reads 0.
6. rst_n asserted mid-line while ovalid=1: ovalid, olast and iready drop to 0 without waiting for a clock edge; after release in LINE mode, iready stays 0 until ialign.

Source files
------------

// File: rtl/split_data.sv
// Unpacks wide read-data words into an MSB-first narrow pixel stream, with optional per-line realignment (MODE="LINE").
// Optional macro SPLIT_DATA_UNDERRUN_CNT_EN adds a saturating output-underrun counter.
module split_data #(
  parameter int ISIZE = 256,
  parameter int OSIZE = 24,
  parameter     MODE  = "ONCE"
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             ialign,
  input  logic             ivalid,
  output logic             iready,
  input  logic [ISIZE-1:0] idata,
  input  logic [15:0]      line_pixels,
  output logic             ovalid,
  input  logic             oready,
  output logic [OSIZE-1:0] odata,
  output logic             olast
`ifdef SPLIT_DATA_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      ounderrun_cnt
`endif
);

  localparam int BW   = ISIZE + 2*OSIZE;
  localparam bit LINE = (MODE == "LINE");

  logic [BW-1:0]      bbuf, bbuf_s, bbuf_nxt;
  logic [10:0]        cnt, cnt_s, cnt_nxt;
  logic [15:0]        pcnt, lpix;
  logic signed [31:0] rbits;
  logic               room, load, pop, line_end;

  // Refill decision looks only at registered state, never at oready.
  assign room     = (cnt < 11'(2*OSIZE)) && (!LINE || (rbits > 0));
  assign iready   = rst_n & room & ~ialign;
  assign ovalid   = rst_n & (cnt >= 11'(OSIZE));
  assign odata    = bbuf[BW-1 -: OSIZE];
  assign olast    = LINE & ovalid & (pcnt == lpix - 16'd1);
  assign load     = ivalid & iready;
  assign pop      = ovalid & oready;
  assign line_end = pop & olast;

  // Bits below cnt are always zero, so a new word can simply be OR-ed in.
  always_comb begin
    bbuf_s   = pop ? (bbuf << OSIZE) : bbuf;
    cnt_s    = pop ? (cnt - 11'(OSIZE)) : cnt;
    bbuf_nxt = bbuf_s;
    cnt_nxt  = cnt_s;
    if (load) begin
      bbuf_nxt = bbuf_s | ({idata, {(2*OSIZE){1'b0}}} >> cnt_s);
      cnt_nxt  = cnt_s + 11'(ISIZE);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bbuf  <= '0;
      cnt   <= '0;
      pcnt  <= '0;
      lpix  <= '0;
      rbits <= '0;
    end else if (ialign || line_end) begin
      // Line end drops the padding tail and re-arms the fetch budget.
      bbuf  <= '0;
      cnt   <= '0;
      pcnt  <= '0;
      lpix  <= line_pixels;
      rbits <= 32'(line_pixels) * 32'(OSIZE);
    end else begin
      bbuf <= bbuf_nxt;
      cnt  <= cnt_nxt;
      if (pop)  pcnt  <= pcnt + 16'd1;
      if (load) rbits <= rbits - 32'(ISIZE);
    end
  end

`ifdef SPLIT_DATA_UNDERRUN_CNT_EN
  logic        popped;
  logic [15:0] urun;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      popped <= 1'b0;
      urun   <= '0;
    end else if (ialign) begin
      popped <= 1'b0;
      urun   <= '0;
    end else begin
      if (pop) popped <= 1'b1;
      if (oready && !ovalid && (LINE ? (pcnt != 16'd0) : popped) && (urun != 16'hFFFF))
        urun <= urun + 16'd1;
    end
  end

  assign ounderrun_cnt = urun;
`endif

endmodule
